// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder:
//   - RISC-V funct3 load/store size codes (MEM_B/H/W/BU/HU)
//   - responder FSM state type
//   - helpers for access legality, byte-enable generation and store-lane replication
package dmem_responder_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Alignment / size legality only; the address range check lives in the top
  // because it depends on the RAM depth.
  function automatic logic access_fault(input logic we, input logic [2:0] size,
                                        input logic [1:0] lo);
    logic f;
    case (size)
      MEM_B:   f = 1'b0;
      MEM_BU:  f = we;               // unsigned sizes are load-only
      MEM_H:   f = lo[0];
      MEM_HU:  f = we | lo[0];
      MEM_W:   f = (lo != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      MEM_B:   be = 4'b0001 << lo;
      MEM_H:   be = lo[1] ? 4'b1100 : 4'b0011;
      MEM_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the LSB-aligned store data across every lane it could land in,
  // so the byte enables alone decide what is written.
  function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      MEM_B:   d = {4{wdata[7:0]}};
      MEM_H:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the addressed byte/half out of a RAM word
// and sign- or zero-extends it to 32 bits (little-endian lanes).
//   word : raw 32-bit RAM word
//   addr : low two byte-address bits
//   size : funct3 size code
//   data : extended load result (0 for sizes that are not loads)
module mem_load_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = '0;
    case (size)
      MEM_B:   data = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  data = {24'd0, byte_sel};
      MEM_H:   data = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  data = {16'd0, half_sel};
      MEM_W:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store bus. Accepts one request at a
// time, waits LATENCY cycles, performs the byte/half/word access into a
// word-organised RAM and returns extended load data or an error flag.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_we/size/addr/wdata : store flag, funct3 size, byte address, LSB-aligned store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : extended load data (0 for stores/errors), error flag
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept;
  logic        access;
  logic        acc_we;
  logic [2:0]  acc_size;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [AW-1:0] acc_idx;
  logic        acc_err;
  logic [3:0]  acc_be;
  logic [31:0] acc_lanes;
  logic        wr_en;
  logic [31:0] rd_word;
  logic [31:0] ld_data;
  logic [31:0] rdata_d;

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With LATENCY=0 the access happens on the acceptance edge itself, before
  // the capture registers hold the request, so the live inputs are used then.
  always_comb begin
    accept    = (state_q == ST_IDLE) && req_valid && ready_q;
    access    = ((state_q == ST_WAIT) && (cnt_q == 4'd1)) || (accept && (LATENCY == 0));
    acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    acc_size  = (state_q == ST_IDLE) ? req_size  : size_q;
    acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    acc_idx   = acc_addr[AW+1:2];
    acc_err   = access_fault(acc_we, acc_size, acc_addr[1:0])
              | ((acc_addr >> (AW + 2)) != '0);
    acc_be    = byte_enable(acc_size, acc_addr[1:0]);
    acc_lanes = store_lanes(acc_size, acc_wdata);
    wr_en     = access && acc_we && !acc_err && !rst;
    rd_word   = mem_q[acc_idx];
    rdata_d   = (acc_we || acc_err) ? '0 : ld_data;
  end

  mem_load_align u_align (
    .word (rd_word),
    .addr (acc_addr[1:0]),
    .size (acc_size),
    .data (ld_data)
  );

  // RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_be[i]) mem_q[acc_idx][8*i +: 8] <= acc_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= 4'(LATENCY);
            ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q <= ST_RESP;
              valid_q <= 1'b1;
              rdata_q <= rdata_d;
              err_q   <= acc_err;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_RESP;
            valid_q <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= acc_err;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                         SZ_BU = 3'b100, SZ_HU = 3'b101;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called 1 time unit after a posedge; returns 1 time unit after the
  // response-handshake edge.
  task automatic xact(input logic we, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int lat);
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic store(input string tag, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(1'b1, size, addr, wdata, rd, er, lat);
    check({tag, "_err"}, {31'd0, er}, 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'd2);
  endtask

  task automatic load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(1'b0, size, addr, 32'd0, rd, er, lat);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, {31'd0, er}, 32'd0);
  endtask

  task automatic bad(input string tag, input logic we, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(we, size, addr, wdata, rd, er, lat);
    check({tag, "_err"}, {31'd0, er}, 32'd1);
    check({tag, "_data"}, rd, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wait_cyc;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store/load and latency
    store("sw0", SZ_W, 32'h0, 32'h7FFF_FFFF);
    load ("lw0", SZ_W, 32'h0, 32'h7FFF_FFFF);

    // Byte lanes in word @4
    store("sw4",  SZ_W, 32'h4, 32'h1122_3344);
    store("sb4",  SZ_B, 32'h4, 32'h0000_00FF);
    load ("lb4",  SZ_B,  32'h4, 32'hFFFF_FFFF);
    load ("lbu4", SZ_BU, 32'h4, 32'h0000_00FF);
    load ("lw4a", SZ_W,  32'h4, 32'h1122_33FF);
    store("sb7",  SZ_B, 32'h7, 32'h0000_0080);
    load ("lb7",  SZ_B,  32'h7, 32'hFFFF_FF80);
    load ("lbu6", SZ_BU, 32'h6, 32'h0000_0022);
    load ("lh6",  SZ_H,  32'h6, 32'hFFFF_8022);
    load ("lhu4", SZ_HU, 32'h4, 32'h0000_33FF);
    load ("lw4b", SZ_W,  32'h4, 32'h8022_33FF);

    // Half lanes in word @8
    store("sw8",  SZ_W, 32'h8, 32'h5566_7788);
    store("sh8",  SZ_H, 32'h8, 32'h0000_FFFF);
    load ("lh8",  SZ_H,  32'h8, 32'hFFFF_FFFF);
    load ("lhu8", SZ_HU, 32'h8, 32'h0000_FFFF);
    load ("lw8a", SZ_W,  32'h8, 32'h5566_FFFF);
    store("shA",  SZ_H, 32'hA, 32'h0000_1234);
    load ("lhA",  SZ_H,  32'hA, 32'h0000_1234);
    load ("lw8b", SZ_W,  32'h8, 32'h1234_FFFF);

    // Error cases; none may touch the RAM
    bad("lw_mis",  1'b0, SZ_W,   32'h2,   32'h0);
    bad("lh_mis",  1'b0, SZ_H,   32'h1,   32'h0);
    bad("lhu_mis", 1'b0, SZ_HU,  32'h5,   32'h0);
    bad("sw_oor",  1'b1, SZ_W,   32'h400, 32'hDEAD_BEEF);
    bad("lw_oor",  1'b0, SZ_W,   32'h400, 32'h0);
    bad("sh_mis",  1'b1, SZ_H,   32'h3,   32'h0000_BEEF);
    bad("sz011",   1'b0, 3'b011, 32'h0,   32'h0);
    bad("sbu_st",  1'b1, SZ_BU,  32'h0,   32'h0);
    bad("shu_st",  1'b1, SZ_HU,  32'h8,   32'h0);
    load("lw0_keep", SZ_W, 32'h0, 32'h7FFF_FFFF);
    load("lw8_keep", SZ_W, 32'h8, 32'h1234_FFFF);

    // Top word of the RAM
    store("sw_top",  SZ_W,  32'h3FC, 32'hA5A5_A5A5);
    load ("lw_top",  SZ_W,  32'h3FC, 32'hA5A5_A5A5);
    load ("lbu_top", SZ_BU, 32'h3FF, 32'h0000_00A5);

    // Stalled response: outputs hold, req ignored while busy
    req_we = 1'b0; req_size = SZ_W; req_addr = 32'h4; req_wdata = '0; req_valid = 1'b1;
    @(posedge clk); #1;
    check("stall_busy", {31'd0, req_ready}, 32'd0);
    req_we = 1'b1; req_wdata = 32'h0;   // store attempt held while busy
    wait_cyc = 0;
    while (!rsp_valid && wait_cyc < 20) begin
      check("stall_wait_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("stall_lat", 32'(wait_cyc), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rdata", rsp_rdata, 32'h8022_33FF);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("stall_done_valid", {31'd0, rsp_valid}, 32'd0);
    check("stall_done_ready", {31'd0, req_ready}, 32'd1);
    load("lw4_keep", SZ_W, 32'h4, 32'h8022_33FF);

    // Reset on the edge that would have performed the store
    store("swC", SZ_W, 32'hC, 32'hCAFE_BABE);
    req_we = 1'b1; req_size = SZ_W; req_addr = 32'hC; req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_waiting", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_quiet", {31'd0, rsp_valid}, 32'd0);
    end
    load("lwC_keep", SZ_W, 32'hC, 32'hCAFE_BABE);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
